// File: rtl/keypad_pkg.sv
// Shared constants, FSM state and key encoder for the keypad
// frame decoder.
package keypad_pkg;

  localparam int NUM_SLOTS    = 13;
  localparam int FRAME_LAST   = 161;
  localparam int SAMPLE_FIRST = 10;
  localparam int SAMPLE_PITCH = 10;

  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_CLOCK = 4'd11;
  localparam logic [3:0] KEY_ALARM = 4'd12;

  typedef enum logic {
    IDLE,
    PRESSED
  } key_state_t;

  // Lowest set slot wins: digit 0 highest, alarm lowest.
  function automatic logic [3:0] lowest_key(
    input logic [NUM_SLOTS-1:0] v
  );
    logic [3:0] code;
    code = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) code = 4'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/key_frame_decoder_if.sv
// Scan/key bundle between the serializer side, the decoder and
// the clock/alarm control logic.
interface key_frame_decoder_if #(
  parameter int CNT_W     = 10,
  parameter int NUM_SLOTS = keypad_pkg::NUM_SLOTS
);

  logic                 tick;
  logic                 signal;
  logic [CNT_W-1:0]     count;
  logic                 key_valid;
  logic [3:0]           key_code;
  logic                 key_held;
  logic [NUM_SLOTS-1:0] stable_keys;
  logic                 frame_done;

  modport master (
    output tick,
    output signal,
    input  count,
    input  key_valid,
    input  key_code,
    input  key_held,
    input  stable_keys,
    input  frame_done
  );

  modport slave (
    input  tick,
    input  signal,
    output count,
    output key_valid,
    output key_code,
    output key_held,
    output stable_keys,
    output frame_done
  );

endinterface

// File: rtl/slot_sampler.sv
// Scan counter and per-slot sample-point capture of the serial
// key line.
module slot_sampler #(
  parameter int CNT_W      = 10,
  parameter int FRAME_LAST = keypad_pkg::FRAME_LAST,
  parameter int NUM_SLOTS  = keypad_pkg::NUM_SLOTS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 signal,
  output logic [CNT_W-1:0]     count,
  output logic [NUM_SLOTS-1:0] raw,
  output logic                 frame_done
);

  import keypad_pkg::*;

  logic at_last;

  assign at_last    = count == CNT_W'(FRAME_LAST);
  assign frame_done = tick && at_last;

  // Only the centre of each slot window is sampled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      raw   <= '0;
    end else if (tick) begin
      count <= at_last ? '0 : count + 1'b1;
      if (count == '0) begin
        raw <= '0;
      end else begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          if (count == CNT_W'(SAMPLE_FIRST + k * SAMPLE_PITCH))
            raw[k] <= signal;
        end
      end
    end
  end

endmodule

// File: rtl/key_frame_decoder.sv
// Keypad frame decoder: frame debounce, stable key vector and
// press-event FSM on top of the slot sampler.
module key_frame_decoder #(
  parameter int CNT_W           = 10,
  parameter int FRAME_LAST      = keypad_pkg::FRAME_LAST,
  parameter int NUM_SLOTS       = keypad_pkg::NUM_SLOTS,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic                clk,
  input  logic                reset,
  key_frame_decoder_if.slave  bus
);

  import keypad_pkg::*;

  logic [CNT_W-1:0]     count;
  logic [NUM_SLOTS-1:0] raw;
  logic                 frame_done;
  logic [NUM_SLOTS-1:0] cand;
  logic [NUM_SLOTS-1:0] stable;
  logic [2:0]           deb_cnt;
  key_state_t           state;
  key_state_t           state_nx;
  logic [3:0]           code_q;
  logic [3:0]           code_nx;
  logic                 fire;

  slot_sampler #(
    .CNT_W      (CNT_W),
    .FRAME_LAST (FRAME_LAST),
    .NUM_SLOTS  (NUM_SLOTS)
  ) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .tick       (bus.tick),
    .signal     (bus.signal),
    .count      (count),
    .raw        (raw),
    .frame_done (frame_done)
  );

  // Any frame that differs from the candidate restarts the run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cand    <= '0;
      deb_cnt <= '0;
      stable  <= '0;
    end else begin
      if (frame_done) begin
        if (raw == cand) begin
          if (deb_cnt < 3'(DEBOUNCE_FRAMES))
            deb_cnt <= deb_cnt + 3'd1;
        end else begin
          cand    <= raw;
          deb_cnt <= 3'd1;
        end
      end
      if (deb_cnt == 3'(DEBOUNCE_FRAMES))
        stable <= cand;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      code_q <= '0;
    end else begin
      state  <= state_nx;
      code_q <= code_nx;
    end
  end

  always_comb begin
    state_nx = state;
    code_nx  = code_q;
    fire     = 1'b0;
    unique case (state)
      IDLE: begin
        if (stable != '0) begin
          state_nx = PRESSED;
          code_nx  = lowest_key(stable);
          fire     = 1'b1;
        end
      end
      PRESSED: begin
        if (stable == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.count       = count;
  assign bus.frame_done  = frame_done;
  assign bus.stable_keys = stable;
  assign bus.key_valid   = fire;
  assign bus.key_code    = code_nx;
  assign bus.key_held    = state == PRESSED;

endmodule

// File: tb/tb_key_frame_decoder.sv
// Scoreboard bench for key_frame_decoder: directed key frames,
// event queue checked by an independent monitor.
module tb_key_frame_decoder;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  key_frame_decoder_if bus ();

  key_frame_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  code;
    logic [12:0] keys;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_fd = -100;
  int          events = 0;
  logic [12:0] keys = '0;
  logic        glitch = 1'b0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  function automatic logic sig_for(int c);
    logic s;
    s = 1'b0;
    if (glitch && (c == 15 || c == 16 || c == 25 || c == 161))
      s = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (keys[k] && c >= 10 * k + 7 && c <= 10 * k + 14)
        s = 1'b1;
    end
    return s;
  endfunction

  initial begin
    bus.signal = 1'b0;
    forever begin
      @(negedge clk);
      bus.signal = sig_for(int'(bus.count));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (bus.frame_done) last_fd = cyc;
    if (reset && bus.key_valid) begin
      events++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got code %0d, want none",
                 bus.key_code);
      end else begin
        e = sbq.pop_front();
        check("ev_code", int'(bus.key_code), int'(e.code));
        check("ev_keys", int'(bus.stable_keys), int'(e.keys));
        check("ev_latency", cyc - last_fd, 2);
      end
    end
  end

  task automatic run_frames(int n);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.frame_done && t < 400);
      if (!bus.frame_done) begin
        checks++;
        errors++;
        $display("FAIL frame_timeout: got no frame_done, want one");
      end
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int exp_cnt;
    int fd;
    int t;
    bus.tick = 1'b0;
    reset    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", int'(bus.count), 0);
    check("rst_valid", int'(bus.key_valid), 0);
    check("rst_code", int'(bus.key_code), 0);
    check("rst_held", int'(bus.key_held), 0);
    check("rst_stable", int'(bus.stable_keys), 0);
    check("rst_fd", int'(bus.frame_done), 0);

    reset    = 1'b1;
    bus.tick = 1'b1;
    exp_cnt  = 0;
    fd       = 0;
    for (int i = 0; i < 324; i++) begin
      @(negedge clk);
      exp_cnt = (exp_cnt == 161) ? 0 : exp_cnt + 1;
      check("count", int'(bus.count), exp_cnt);
      if (bus.frame_done) fd++;
    end
    check("fd_pulses", fd, 2);
    check("wrap_stable", int'(bus.stable_keys), 0);
    check("wrap_held", int'(bus.key_held), 0);

    bus.tick = 1'b0;
    repeat (5) @(negedge clk);
    check("hold_count", int'(bus.count), exp_cnt);
    bus.tick = 1'b1;
    run_frames(1);

    // single key in slot 4
    keys = 13'h0010;
    run_frames(2);
    sbq.push_back('{4'd4, 13'h0010});
    run_frames(1);
    settle();
    check("k4_held", int'(bus.key_held), 1);
    check("k4_stable", int'(bus.stable_keys), 'h10);
    keys = '0;
    run_frames(3);
    settle();
    check("k4_rel_held", int'(bus.key_held), 0);
    check("k4_rel_stable", int'(bus.stable_keys), 0);
    check("k4_code_kept", int'(bus.key_code), 4);

    // bouncing enter key
    keys = 13'h0400;
    run_frames(2);
    keys = '0;
    run_frames(1);
    keys = 13'h0400;
    run_frames(2);
    sbq.push_back('{4'd10, 13'h0400});
    run_frames(1);
    settle();
    check("ent_held", int'(bus.key_held), 1);
    keys = '0;
    run_frames(3);
    settle();
    check("ent_rel_held", int'(bus.key_held), 0);

    // priority and rollover
    keys = 13'h1008;
    run_frames(2);
    sbq.push_back('{4'd3, 13'h1008});
    run_frames(1);
    settle();
    keys = 13'h1000;
    run_frames(3);
    settle();
    check("roll_held", int'(bus.key_held), 1);
    check("roll_stable", int'(bus.stable_keys), 'h1000);
    check("roll_code", int'(bus.key_code), 3);
    keys = '0;
    run_frames(3);
    settle();
    check("roll_rel_held", int'(bus.key_held), 0);

    // glitches off the sample points
    glitch = 1'b1;
    run_frames(5);
    glitch = 1'b0;
    settle();
    check("gl_stable", int'(bus.stable_keys), 0);
    check("gl_held", int'(bus.key_held), 0);

    // reset in the middle of the third frame
    keys = 13'h0080;
    run_frames(2);
    t = 0;
    while (bus.count != 10'd80 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("mid_found80", int'(bus.count), 80);
    reset = 1'b0;
    @(negedge clk);
    check("mid_count", int'(bus.count), 0);
    check("mid_stable", int'(bus.stable_keys), 0);
    reset = 1'b1;
    run_frames(2);
    sbq.push_back('{4'd7, 13'h0080});
    run_frames(1);
    settle();
    check("mid_held", int'(bus.key_held), 1);
    check("mid_code", int'(bus.key_code), 7);

    check("queue_empty", sbq.size(), 0);
    check("event_count", events, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_frame_decoder.md
Name: key_frame_decoder

Overview:
- Receive-side counterpart of the keypad time-slot serializer.
- Owns the scan counter (drives the serializer's `count` input) and samples the single serial `signal` line once per slot.
- Rebuilds the 13-key frame (digits 0-9, enter, clock, alarm) and debounces it across frames.
- Emits one-cycle key events to the clock/alarm control logic.

Parameters:
- CNT_W, 10, width of scan counter output.
- FRAME_LAST, 161, last count value of a frame; the counter wraps to 0 after it.
- NUM_SLOTS, 13, number of key slots per frame.
- DEBOUNCE_FRAMES, 3, number of consecutive identical frames required before a frame is accepted as stable (range 1-7).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- tick  in  1  scan-advance enable; the counter steps only when tick=1.
- signal  in  1  serial key line from the serializer.
- count  out  CNT_W  scan counter; feeds the serializer's `count` input.
- key_valid  out  1  one-cycle pulse: new key pressed.
- key_code  out  4  0-9 digit, 10 enter, 11 clock, 12 alarm; held until the next event.
- key_held  out  1  1 while any key is stable-pressed.
- stable_keys  out  NUM_SLOTS  debounced key vector, bit k = slot k.
- frame_done  out  1  one-cycle pulse at frame end (count==FRAME_LAST with tick).

Behaviour:
- **Reset** (reset=0 at posedge clk): count=0, key_valid=0, key_code=0, key_held=0, stable_keys=0, frame_done=0, shift/candidate registers=0, debounce counter=0, FSM=IDLE.
- **Counter:**
  - On tick: count <= (count==FRAME_LAST) ? 0 : count+1.
  - With tick=0 the counter holds.
  - count never exceeds FRAME_LAST.
- **Slot windows:** slot k (k=0..12) is open for 10k+5 < count < 10k+15. The sample point is count == 10k+10.
- **Sampling:**
  - On a tick cycle where count equals a sample point, raw[k] <= signal.
  - raw is cleared at the first tick of a new frame (count==0).
  - Samples outside windows are ignored.
- **Frame end** (tick && count==FRAME_LAST):
  - frame_done pulses for that cycle.
  - If raw == candidate: deb_cnt <= min(deb_cnt+1, DEBOUNCE_FRAMES).
  - Otherwise: candidate <= raw and deb_cnt <= 1.
  - When deb_cnt reaches DEBOUNCE_FRAMES, stable_keys <= candidate on the following cycle (1-cycle latency after frame_done).
- **FSM** (evaluated the cycle after stable_keys updates):
  - IDLE: if stable_keys != 0 → PRESSED.
    - key_code <= index of the lowest set bit (priority: digit 0 highest, alarm lowest).
    - key_valid pulses 1 cycle.
  - PRESSED: key_held=1.
    - If stable_keys == 0 → IDLE.
    - If additional bits set or other bits change while at least one bit stays set: no new event (rollover suppressed).
    - If the key_code bit clears but another bit remains set: no event; remain PRESSED until all keys are released.
  - key_held=0 in IDLE.
- **Latency:** key_valid asserts exactly 2 clk after the frame_done that completed debounce.
- **Boundaries:**
  - tick asserted every clk is legal.
  - reset mid-frame aborts the frame: partial raw is discarded and the count restarts at 0.
  - signal glitches between sample points have no effect.
  - A frame that differs from candidate restarts debounce even if it matches stable_keys.
  - stable_keys changes only on debounce completion.

Decomposition:
- Package `keypad_pkg`:
  - key code constants (KEY_ENTER=10, KEY_CLOCK=11, KEY_ALARM=12).
  - NUM_SLOTS, FRAME_LAST.
  - slot base/offset constants (first sample 10, pitch 10).
  - FSM state enum {IDLE, PRESSED}.
- One sub-module, `slot_sampler`:
  - Holds the counter and the sample-point decode.
  - Produces raw[12:0], frame_done, count.
- The top level holds debounce, stable_keys, FSM and encoding.

Test Plan:
- **Reset/wrap:** hold reset=0 for 3 clk, then tick continuously → count steps 0..161 then returns to 0; frame_done pulses exactly once per 162 ticks; all other outputs remain 0.
- **Single key, DEBOUNCE_FRAMES=3:** drive signal=1 only while count in 47..54 (slot 4) for 3 frames → stable_keys=13'h0010 after the 3rd frame_done; key_valid pulse with key_code=4 two clk after it; key_held=1; drive idle for 3 frames → key_held=0 with no further pulse.
- **Bounce:** slot 10 (enter) pressed in frames 1 and 2, absent in frame 3, present in frames 4-6 → exactly one key_valid with key_code=10, after frame 6.
- **Priority/rollover:** slots 3 and 12 pressed together for 3 frames → key_code=3, single pulse; then release slot 3 while slot 12 stays set → no new pulse, key_held stays 1.
- **Off-window glitch:** signal=1 only at counts 15, 16, 25 and 161 for 5 frames → raw stays 0; no key_valid.
- **Mid-frame reset:** slot 7 pressed for 2 frames, reset=0 for 1 clk at count=80 of frame 3 → count=0, debounce cleared; the key needs 3 further full frames before key_valid with key_code=7.
